// File: rtl/jpeg_color_pkg.sv
// jpeg_color_pkg
// Shared constants and pixel types for the JPEG colour-space converters.
// Coefficients are Q(COEF_FRAC) integers. The forward (RGB->YCbCr) set is
// kept here too, so both directions of the codec use one fixed-point
// convention.
package jpeg_color_pkg;

  localparam int COEF_FRAC     = 14;
  localparam int PIX_W         = 8;
  localparam int CHROMA_OFFSET = 128;

  // Inverse path (YCbCr -> RGB)
  localparam int K_RCR = 22970;  // 1.402
  localparam int K_GCB = 5638;   // 0.344136
  localparam int K_GCR = 11700;  // 0.714136
  localparam int K_BCB = 29032;  // 1.772

  // Forward path (RGB -> YCbCr)
  localparam int K_YR  = 4899;   // 0.299
  localparam int K_YG  = 9617;   // 0.587
  localparam int K_YB  = 1868;   // 0.114
  localparam int K_CBR = 2765;   // 0.168736
  localparam int K_CBG = 5427;   // 0.331264
  localparam int K_CBB = 8192;   // 0.5
  localparam int K_CRR = 8192;   // 0.5
  localparam int K_CRG = 6860;   // 0.418688
  localparam int K_CRB = 1332;   // 0.081312

  typedef struct packed {
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] cb;
    logic [PIX_W-1:0] cr;
  } pix_ycc_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_rgb_t;

endpackage

// File: rtl/ycc2rgb_round_clamp.sv
// ycc2rgb_round_clamp
// Converts one Q(FRAC) signed sum to an 8-bit pixel: round half up,
// arithmetic shift right by FRAC, then saturate to 0..255.
// Ports:
//   sum  in   27-bit signed fixed-point component
//   pix  out  8-bit unsigned clamped component
module ycc2rgb_round_clamp
  import jpeg_color_pkg::*;
#(
  parameter int FRAC = COEF_FRAC
) (
  input  logic signed [26:0] sum,
  input  logic               unused_tie,
  output logic [7:0]         pix
);

  localparam logic signed [26:0] ROUND = 27'sd1 <<< (FRAC - 1);

  logic signed [26:0] rounded;
  logic signed [26:0] shifted;

  always_comb begin
    rounded = sum + ROUND;
    shifted = rounded >>> FRAC;
    pix     = 8'd0;
    if (shifted < 27'sd0) begin
      pix = 8'd0;
    end else if (shifted > 27'sd255) begin
      pix = 8'd255;
    end else begin
      pix = shifted[7:0];
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/ycbcr_to_rgb_convert.sv
// ycbcr_to_rgb_convert
// Streaming full-range YCbCr -> RGB converter. Three-stage stallable
// pipeline (offset/scale, multiply, sum+round+clamp into output regs) with
// valid/ready on both sides, and an end-of-block marker every BLOCK_PIXELS
// output pixels.
// Ports:
//   ap_clk, ap_rst_n         clock, async active-low reset
//   s_valid/s_ready          input handshake
//   s_y, s_cb, s_cr          8-bit input components
//   m_valid/m_ready          output handshake
//   m_r, m_g, m_b            8-bit output components
//   m_last                   last pixel of the current block
module ycbcr_to_rgb_convert
  import jpeg_color_pkg::*;
#(
  parameter int BLOCK_PIXELS = 64
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_y,
  input  logic [7:0] s_cb,
  input  logic [7:0] s_cr,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_r,
  output logic [7:0] m_g,
  output logic [7:0] m_b,
  output logic       m_last
);

  localparam int CNT_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_PIXELS - 1);
  localparam logic signed [8:0]  OFS    = 9'(CHROMA_OFFSET);
  localparam logic signed [15:0] C_RCR  = 16'(K_RCR);
  localparam logic signed [15:0] C_GCB  = 16'(K_GCB);
  localparam logic signed [15:0] C_GCR  = 16'(K_GCR);
  localparam logic signed [15:0] C_BCB  = 16'(K_BCB);

  logic en;

  // Stage 1
  logic              v1;
  logic signed [23:0] y_s;
  logic signed [8:0]  cb_d;
  logic signed [8:0]  cr_d;

  // Stage 2
  logic              v2;
  logic signed [23:0] y2;
  logic signed [24:0] p_rcr;
  logic signed [24:0] p_gcb;
  logic signed [24:0] p_gcr;
  logic signed [24:0] p_bcb;

  // Stage 3 combinational sums and clamped results (order: R, G, B)
  logic signed [26:0] sums [3];
  logic [7:0]         pix  [3];

  logic [CNT_W-1:0] cnt;

  // A full output register that is not being drained freezes the whole
  // pipeline; this is the only stall source, so it is also the input ready.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1   <= 1'b0;
      y_s  <= '0;
      cb_d <= '0;
      cr_d <= '0;
    end else if (en) begin
      v1   <= s_valid;
      y_s  <= $signed(24'(s_y) << COEF_FRAC);
      cb_d <= $signed({1'b0, s_cb}) - OFS;
      cr_d <= $signed({1'b0, s_cr}) - OFS;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v2    <= 1'b0;
      y2    <= '0;
      p_rcr <= '0;
      p_gcb <= '0;
      p_gcr <= '0;
      p_bcb <= '0;
    end else if (en) begin
      v2    <= v1;
      y2    <= y_s;
      p_rcr <= 25'(C_RCR) * 25'(cr_d);
      p_gcb <= 25'(C_GCB) * 25'(cb_d);
      p_gcr <= 25'(C_GCR) * 25'(cr_d);
      p_bcb <= 25'(C_BCB) * 25'(cb_d);
    end
  end

  // 27 bits covers y_s (<2^23) plus two products (<2^24 each) without wrap.
  assign sums[0] = 27'(y2) + 27'(p_rcr);
  assign sums[1] = 27'(y2) - 27'(p_gcb) - 27'(p_gcr);
  assign sums[2] = 27'(y2) + 27'(p_bcb);

  for (genvar gi = 0; gi < 3; gi++) begin : g_rc
    ycc2rgb_round_clamp #(.FRAC(COEF_FRAC)) u_rc (
      .sum        (sums[gi]),
      .unused_tie (1'b0),
      .pix        (pix[gi])
    );
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_valid <= 1'b0;
      m_r     <= '0;
      m_g     <= '0;
      m_b     <= '0;
    end else if (en) begin
      m_valid <= v2;
      m_r     <= pix[0];
      m_g     <= pix[1];
      m_b     <= pix[2];
    end
  end

  // Counts delivered pixels only, so bubbles and stalls never move it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt <= '0;
    end else if (m_valid && m_ready) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign m_last = m_valid && (cnt == CNT_LAST);

endmodule

// File: tb/tb_ycbcr_to_rgb_convert.sv
module tb_ycbcr_to_rgb_convert;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_y, s_cb, s_cr;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_r, m_g, m_b;
  logic       m_last;

  ycbcr_to_rgb_convert #(.BLOCK_PIXELS(64)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_y      (s_y),
    .s_cb     (s_cb),
    .s_cr     (s_cr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_r      (m_r),
    .m_g      (m_g),
    .m_b      (m_b),
    .m_last   (m_last)
  );

  always #5 ap_clk = ~ap_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic [7:0] r, g, b;
  } vec_t;

  typedef struct {
    logic [7:0] r, g, b;
    int         cyc;
  } exp_t;

  vec_t vecs [8];
  exp_t exp_q [$];
  int   last_idx [$];
  int   out_count = 0;
  bit   lat_check = 1'b0;
  logic [7:0] d_r, d_g, d_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard, sampling on the falling edge.
  initial begin : monitor
    logic       stall_prev;
    logic [7:0] hr, hg, hb;
    logic       hl;
    exp_t       e;
    stall_prev = 1'b0;
    hr = 0; hg = 0; hb = 0; hl = 0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n) begin
        if (stall_prev) begin
          check("stall_hold_valid", 32'(m_valid), 1);
          check("stall_hold_rgb", {8'd0, m_r, m_g, m_b}, {8'd0, hr, hg, hb});
          check("stall_hold_last", 32'(m_last), 32'(hl));
        end
        if (m_valid && !m_ready) check("s_ready_while_stalled", 32'(s_ready), 0);
        if (m_valid && m_ready) begin
          check("output_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("out%0d_r", out_count), 32'(m_r), 32'(e.r));
            check($sformatf("out%0d_g", out_count), 32'(m_g), 32'(e.g));
            check($sformatf("out%0d_b", out_count), 32'(m_b), 32'(e.b));
            if (lat_check) check($sformatf("out%0d_latency", out_count), 32'(cyc - e.cyc), 3);
          end
          check($sformatf("out%0d_last", out_count), 32'(m_last), 32'((out_count % 64) == 63));
          if (m_last) last_idx.push_back(out_count);
          out_count++;
        end
        if (s_valid && s_ready) begin
          e.r = d_r; e.g = d_g; e.b = d_b; e.cyc = cyc;
          exp_q.push_back(e);
        end
        stall_prev = m_valid && !m_ready;
        hr = m_r; hg = m_g; hb = m_b; hl = m_last;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // All main-thread tasks start and end at posedge+1.
  task automatic send(input logic [7:0] y, cb, cr, r, g, b, input bit bp);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    s_y = y; s_cb = cb; s_cr = cr;
    d_r = r; d_g = g; d_b = b;
    s_valid = 1'b1;
    while (!done && n < 200) begin
      if (bp) m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_ready) done = 1'b1;
      @(posedge ap_clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    check("send_accepted", 32'(done), 1);
  endtask

  task automatic send_gray(input logic [7:0] y);
    send(y, 8'd128, 8'd128, y, y, y, 1'b0);
  endtask

  task automatic drain(input bit bp);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      if (bp) m_ready = 1'($urandom_range(0, 1));
      @(posedge ap_clk);
      #1;
      n++;
    end
    m_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    #1;
    ap_rst_n = 1'b0;
    exp_q.delete();
    last_idx.delete();
    out_count = 0;
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int c0;
    int oc0;

    vecs[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    vecs[1] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd135, 8'd0  };
    vecs[3] = '{8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0  };
    vecs[4] = '{8'd255, 8'd255, 8'd128, 8'd255, 8'd211, 8'd255};
    vecs[5] = '{8'd100, 8'd128, 8'd128, 8'd100, 8'd100, 8'd100};
    vecs[6] = '{8'd0,   8'd128, 8'd255, 8'd178, 8'd0,   8'd0  };
    vecs[7] = '{8'd128, 8'd0,   8'd128, 8'd128, 8'd172, 8'd0  };

    ap_rst_n = 1'b0;
    s_valid = 1'b0;
    s_y = 0; s_cb = 0; s_cr = 0;
    d_r = 0; d_g = 0; d_b = 0;
    m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_rgb", {8'd0, m_r, m_g, m_b}, 0);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("post_rst_s_ready", 32'(s_ready), 1);
    check("post_rst_m_valid", 32'(m_valid), 0);

    // Single vectors: latency and values
    lat_check = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].y, vecs[i].cb, vecs[i].cr, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
      lat = 1;
      while (!m_valid && lat < 10) begin
        @(posedge ap_clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 3);
      check($sformatf("vec%0d_r", i), 32'(m_r), 32'(vecs[i].r));
      check($sformatf("vec%0d_g", i), 32'(m_g), 32'(vecs[i].g));
      check($sformatf("vec%0d_b", i), 32'(m_b), 32'(vecs[i].b));
      drain(1'b0);
    end

    // Back-to-back stream: one pixel per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(vecs[i].y, vecs[i].cb, vecs[i].cr, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
    check("throughput_cycles", 32'(cyc - c0), 8);
    drain(1'b0);

    // Back-pressure
    lat_check = 1'b0;
    oc0 = out_count;
    for (int i = 0; i < 10; i++) begin
      int k;
      k = (i * 3) % 8;
      send(vecs[k].y, vecs[k].cb, vecs[k].cr, vecs[k].r, vecs[k].g, vecs[k].b, 1'b1);
    end
    drain(1'b1);
    check("bp_output_count", 32'(out_count - oc0), 10);
    lat_check = 1'b1;

    // Block marker over 130 pixels from a clean reset
    do_reset();
    for (int i = 0; i < 130; i++) send_gray(8'(i));
    drain(1'b0);
    check("block_last_count", 32'(last_idx.size()), 2);
    if (last_idx.size() >= 2) begin
      check("block_last_first", 32'(last_idx[0]), 63);
      check("block_last_second", 32'(last_idx[1]), 127);
    end

    // Reset with pixels in flight
    for (int i = 0; i < 4; i++) send_gray(8'(200 + i));
    check("pre_reset_m_valid", 32'(m_valid), 1);
    #1;
    ap_rst_n = 1'b0;
    exp_q.delete();
    last_idx.delete();
    out_count = 0;
    #1;
    check("mid_reset_m_valid", 32'(m_valid), 0);
    check("mid_reset_m_last", 32'(m_last), 0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("after_reset_m_valid", 32'(m_valid), 0);
    for (int i = 0; i < 70; i++) send_gray(8'(i + 10));
    drain(1'b0);
    check("new_block_last_count", 32'(last_idx.size()), 1);
    if (last_idx.size() >= 1) check("new_block_last_index", 32'(last_idx[0]), 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ycbcr_to_rgb_convert.md
# ycbcr_to_rgb_convert

Streaming inverse colour-space converter for the decode/preview path: accepts 8-bit Y/Cb/Cr pixels (JPEG/JFIF full-range, chroma offset 128) and produces 8-bit R/G/B pixels. It is the counterpart of the forward RGB→YCbCr converter on the compression path, sharing its fixed-point coefficient convention. The datapath is a 3-stage stallable pipeline with valid/ready handshakes on both sides. It also regenerates an end-of-block marker every BLOCK_PIXELS outputs.

## Interface
- COEF_FRAC, 14: fractional bits of the fixed-point coefficients.
- BLOCK_PIXELS, 64: output pixels per block; `m_last` is asserted on the last pixel of each block.
- ap_clk  in  1  clock; all state on the rising edge.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input accepted when `s_valid && s_ready`.
- s_y, s_cb, s_cr  in  8 each  unsigned input components.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts the pixel when `m_valid && m_ready`.
- m_r, m_g, m_b  out  8 each  unsigned output components.
- m_last  out  1  last pixel of the current BLOCK_PIXELS group.

## Operation
- Coefficients are Q(COEF_FRAC) integers, with values for COEF_FRAC=14:
  - K_RCR = 22970 (1.402)
  - K_GCB = 5638 (0.344136)
  - K_GCR = 11700 (0.714136)
  - K_BCB = 29032 (1.772)
- Stage 1 computes and registers three values:
  - `y_s = Y << COEF_FRAC`, signed 24 bits.
  - `cb_d = Cb − 128`, signed 9 bits.
  - `cr_d = Cr − 128`, signed 9 bits.
- Stage 2 computes and registers four signed 25-bit products: `K_RCR*cr_d`, `K_GCB*cb_d`, `K_GCR*cr_d`, `K_BCB*cb_d`. `y_s` is carried alongside.
- Stage 3 forms three sums, each signed 27 bits with no intermediate overflow:
  - `R = y_s + K_RCR*cr_d`
  - `G = y_s − K_GCB*cb_d − K_GCR*cr_d`
  - `B = y_s + K_BCB*cb_d`
- Each sum then gets rounding offset `1 << (COEF_FRAC−1)`, an arithmetic right shift by COEF_FRAC, and a clamp:
  - result < 0 → 0
  - result > 255 → 255
  - otherwise the low 8 bits.
- Block counter:
  - Range 0..BLOCK_PIXELS−1; it advances on each output handshake.
  - `m_last = (count == BLOCK_PIXELS−1) && m_valid`.
  - It wraps to 0 after the last pixel.

## Timing
- Reset values:
  - `m_valid=0`, `m_last=0`, `m_r=m_g=m_b=0`.
  - All stage valid bits 0; block counter 0.
  - `s_ready=1` after reset deassertion.
- Pipeline enable: `en = !m_valid || m_ready`.
  - `s_ready = en`, purely combinational, with no dependency on `s_valid`.
  - When `en` is high, all stages advance and valid bits shift.
  - When `en` is low, all stage registers, including data, hold.
- Latency: a pixel accepted in cycle N appears on `m_*` in cycle N+3 if `m_ready` stays high.
  - Throughput is 1 pixel/cycle.
- Bubbles: a stage-1 valid bit of 0 propagates as a bubble.
  - Bubbles do not advance the block counter.
  - Data registers may update freely under bubbles.
- Output stability: while `m_valid && !m_ready`, `m_r/m_g/m_b/m_last` stay stable.
- Simultaneous events:
  - Input and output handshakes in the same cycle are both honoured.
  - The counter increments only on the output handshake.
- Reset mid-stream: any in-flight pixels are discarded, the counter returns to 0, and the next accepted pixel starts a new block.

## Structure
- Package `jpeg_color_pkg` holds:
  - COEF_FRAC
  - The four inverse coefficients as localparams, alongside the forward-path coefficients.
  - Pixel width (8) and CHROMA_OFFSET (128).
  - A `pix_ycc_t` and a `pix_rgb_t` struct, with three 8-bit fields each.
- Sub-module `ycc2rgb_round_clamp` has a signed 27-bit input and an 8-bit output, implementing round, shift and saturate. It is instantiated three times in stage 3.

## Test plan
- Y=128, Cb=128, Cr=128 → R,G,B = 128,128,128; `m_valid` rises exactly 3 cycles after acceptance.
- Y=255, Cb=128, Cr=255 → 255,164,255. R saturates high; G = (4177920−1485900+8192)>>14 = 164.
- Y=0, Cb=0, Cr=0 → 0,135,0. R and B clamp low; G = (2219264+8192)>>14 = 135.
- Y=76, Cb=85, Cr=255 → 254,0,0.
- Back-pressure: stream 10 pixels while toggling `m_ready` pseudo-randomly. Required: no loss, no duplication, in-order output, data stable while stalled, `s_ready` low whenever `m_valid && !m_ready`.
- Block marker and reset:
  - Stream 130 pixels with `m_ready=1` → `m_last` on output pixels 64 and 128 only.
  - Assert `ap_rst_n=0` with 2 pixels in flight → `m_valid` drops immediately.
  - After release, `m_last` next falls on the 64th new pixel.
